// File: rtl/blake2_hash_arbiter.sv
// Round-robin lock arbiter sharing one BLAKE2 compression core between N_REQ
// message controllers; a requester owns the core from INIT through its digest.
module blake2_hash_arbiter #(
  parameter int N_REQ       = 2,
  parameter int BLOCK_WIDTH = 8,
  parameter int DATA_LENGTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_REQ-1:0]             i_cmd_valid,
  input  logic [2*N_REQ-1:0]           i_cmd_op,
  input  logic [N_REQ*BLOCK_WIDTH-1:0] i_cmd_block,
  input  logic [N_REQ*DATA_LENGTH-1:0] i_cmd_length,
  output logic [N_REQ-1:0]             o_cmd_ready,
  output logic [N_REQ-1:0]             o_done,
  output logic [N_REQ-1:0]             o_owner,
  output logic                         o_err,
  output logic                         o_init,
  output logic                         o_next,
  output logic                         o_final,
  output logic [BLOCK_WIDTH-1:0]       o_block,
  output logic [DATA_LENGTH-1:0]       o_data_length,
  input  logic                         i_hash_ready,
  input  logic                         i_digest_valid
);
  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] OP_ILL  = 2'b00;
  localparam logic [1:0] OP_INIT = 2'b01;
  localparam logic [1:0] OP_NEXT = 2'b10;
  localparam logic [1:0] OP_FIN  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOCKED, S_ISSUE, S_BUSY, S_DIGEST} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_rr;
  logic [IW-1:0]         r_own_idx;
  logic [1:0]            r_op;
  logic                  r_guard;

  logic [N_REQ-1:0]      w_init_req;
  logic [IW-1:0]         w_win;
  logic                  w_win_vld;
  logic [IW-1:0]         w_acc_idx;
  logic [1:0]            w_acc_op;
  logic [BLOCK_WIDTH-1:0] w_acc_blk;
  logic [DATA_LENGTH-1:0] w_acc_len;
  logic                  w_acc;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      w_init_req[i] = i_cmd_valid[i] && (i_cmd_op[2*i +: 2] == OP_INIT);
  end

  // Walk downward so the last hit is the first eligible index at or above rr.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (w_init_req[(int'(r_rr) + k) % N_REQ]) begin
        w_win     = IW'((int'(r_rr) + k) % N_REQ);
        w_win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    o_cmd_ready = '0;
    if (i_hash_ready) begin
      if (r_state == S_IDLE && w_win_vld)
        o_cmd_ready[w_win] = 1'b1;
      else if (r_state == S_LOCKED && i_cmd_valid[r_own_idx])
        o_cmd_ready[r_own_idx] = 1'b1;
    end
  end

  assign w_acc     = |o_cmd_ready;
  assign w_acc_idx = (r_state == S_IDLE) ? w_win : r_own_idx;

  always_comb begin
    w_acc_op  = '0;
    w_acc_blk = '0;
    w_acc_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_acc_idx == IW'(i)) begin
        w_acc_op  = i_cmd_op[2*i +: 2];
        w_acc_blk = i_cmd_block[i*BLOCK_WIDTH +: BLOCK_WIDTH];
        w_acc_len = i_cmd_length[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_own_idx     <= '0;
      r_op          <= '0;
      r_guard       <= 1'b0;
      o_owner       <= '0;
      o_done        <= '0;
      o_err         <= 1'b0;
      o_init        <= 1'b0;
      o_next        <= 1'b0;
      o_final       <= 1'b0;
      o_block       <= '0;
      o_data_length <= '0;
    end else begin
      o_init  <= 1'b0;
      o_next  <= 1'b0;
      o_final <= 1'b0;
      o_err   <= 1'b0;
      o_done  <= '0;
      case (r_state)
        S_IDLE, S_LOCKED: begin
          if (w_acc) begin
            if (r_state == S_IDLE) begin
              o_owner   <= o_cmd_ready;
              r_own_idx <= w_acc_idx;
            end
            // An illegal opcode is swallowed without touching the core.
            if (w_acc_op == OP_ILL) begin
              o_err <= 1'b1;
            end else begin
              r_op          <= w_acc_op;
              o_block       <= w_acc_blk;
              o_data_length <= w_acc_len;
              o_init        <= (w_acc_op == OP_INIT);
              o_next        <= (w_acc_op == OP_NEXT);
              o_final       <= (w_acc_op == OP_FIN);
              r_state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_guard <= 1'b1;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          // Core may still show the pre-command hash_ready in the first cycle.
          if (r_guard)
            r_guard <= 1'b0;
          else if (i_hash_ready)
            r_state <= (r_op == OP_FIN) ? S_DIGEST : S_LOCKED;
        end
        S_DIGEST: begin
          if (i_digest_valid) begin
            o_done  <= o_owner;
            o_owner <= '0;
            r_rr    <= (r_own_idx == IW'(N_REQ-1)) ? '0 : r_own_idx + IW'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blake2_hash_arbiter.sv
// Directed bench for blake2_hash_arbiter with a small behavioural core model.
module tb_blake2_hash_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd_valid = '0;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_block = '0;
  logic [15:0] cmd_length = '0;
  logic [1:0]  cmd_ready, done, owner;
  logic        err, c_init, c_next, c_final;
  logic [7:0]  blk, dlen;
  logic        hash_ready, digest_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  blake2_hash_arbiter #(.N_REQ(2), .BLOCK_WIDTH(8), .DATA_LENGTH(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
    .i_cmd_block(cmd_block), .i_cmd_length(cmd_length),
    .o_cmd_ready(cmd_ready), .o_done(done), .o_owner(owner), .o_err(err),
    .o_init(c_init), .o_next(c_next), .o_final(c_final),
    .o_block(blk), .o_data_length(dlen),
    .i_hash_ready(hash_ready), .i_digest_valid(digest_valid)
  );

  // Core: hash_ready low the cycle after a pulse for 4 cycles; digest one cycle after return.
  int   cnt;
  logic fin;
  always @(posedge clk) begin
    if (reset) begin
      hash_ready <= 1'b1; cnt <= 0; fin <= 1'b0; digest_valid <= 1'b0;
    end else if (c_init | c_next | c_final) begin
      hash_ready <= 1'b0; cnt <= 4; fin <= c_final; digest_valid <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) hash_ready <= 1'b1;
    end else if (fin && hash_ready) begin
      digest_valid <= 1'b1; fin <= 1'b0;
    end
  end

  typedef struct { logic [1:0] op; logic [7:0] blk; logic [7:0] len; logic [1:0] own; } ev_t;
  ev_t evq[$];
  ev_t e;
  int n_done0 = 0, n_err = 0, n_rdy1 = 0, n_multi = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (c_init | c_next | c_final) begin
        e.op  = c_init ? 2'd1 : (c_next ? 2'd2 : 2'd3);
        e.blk = blk; e.len = dlen; e.own = owner;
        evq.push_back(e);
      end
      if (done[0]) n_done0++;
      if (err) n_err++;
      if (cmd_ready[1]) n_rdy1++;
      if ($countones(cmd_ready) > 1 || $countones({c_init, c_next, c_final}) > 1) n_multi++;
    end
  end

  task automatic do_reset();
    reset = 1'b1; cmd_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present a command on requester r until accepted; returns at posedge+1 after accept.
  task automatic issue(input int r, input logic [1:0] o, input logic [7:0] b,
                       input logic [7:0] l, output bit ok);
    @(posedge clk); #1;
    cmd_valid[r] = 1'b1; cmd_op[2*r +: 2] = o;
    cmd_block[8*r +: 8] = b; cmd_length[8*r +: 8] = l;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready[r]) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid[r] = 1'b0;
  endtask

  task automatic wait_done(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done[r]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL reset_owner: got %b want 00", owner); end
    tests++; if (done !== 2'b00 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %b/%b want 00/0", done, err); end
    tests++; if ({c_init, c_next, c_final} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {c_init, c_next, c_final}); end
    tests++; if (blk !== 8'h00 || dlen !== 8'h00) begin fails++; $display("FAIL reset_block_len: got %h/%h want 00/00", blk, dlen); end
    tests++; if (cmd_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", cmd_ready); end
  endtask

  task automatic test_single_hash();
    bit ok;
    logic [1:0] eo [3];
    logic [7:0] eb [3];
    logic [7:0] el [3];
    eo = '{2'd1, 2'd2, 2'd3}; eb = '{8'h11, 8'h22, 8'h33}; el = '{8'd8, 8'd8, 8'd3};
    evq.delete(); n_done0 = 0;
    issue(0, 2'b01, 8'h11, 8'd8, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_init_accept: got timeout want accept"); end
    tests++; if (c_init !== 1'b1 || blk !== 8'h11) begin fails++; $display("FAIL single_init_latency: got init=%b blk=%h want 1/11", c_init, blk); end
    tests++; if (owner !== 2'b01) begin fails++; $display("FAIL single_owner: got %b want 01", owner); end
    issue(0, 2'b10, 8'h22, 8'd8, ok);
    issue(0, 2'b11, 8'h33, 8'd3, ok);
    wait_done(0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_done: got timeout want done"); end
    @(negedge clk);
    tests++; if (owner !== 2'b00 || done !== 2'b00) begin fails++; $display("FAIL single_release: got owner=%b done=%b want 00/00", owner, done); end
    tests++; if (n_done0 !== 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", n_done0); end
    tests++; if (blk !== 8'h33 || dlen !== 8'd3) begin fails++; $display("FAIL single_hold: got %h/%0d want 33/3", blk, dlen); end
    tests++; if (evq.size() !== 3) begin fails++; $display("FAIL single_pulse_count: got %0d want 3", evq.size()); end
    for (int i = 0; i < 3 && i < evq.size(); i++) begin
      tests++;
      if (evq[i].op !== eo[i] || evq[i].blk !== eb[i] || evq[i].len !== el[i]) begin
        fails++; $display("FAIL single_pulse%0d: got op=%0d blk=%h len=%0d want op=%0d blk=%h len=%0d",
                          i, evq[i].op, evq[i].blk, evq[i].len, eo[i], eb[i], el[i]);
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    evq.delete();
    cmd_valid = 2'b11; cmd_op = 4'b0101; cmd_block = 16'hB0A0; cmd_length = 16'h0201;
    @(negedge clk);
    tests++; if (cmd_ready !== 2'b01) begin fails++; $display("FAIL contend_ready: got %b want 01", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    tests++; if (owner !== 2'b01) begin fails++; $display("FAIL contend_owner0: got %b want 01", owner); end
    issue(0, 2'b11, 8'hA1, 8'd4, ok);
    wait_done(0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL contend_done0: got timeout want done"); end
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      if (cmd_ready === 2'b10) ok = 1'b1;
      else @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL contend_accept1: got no grant want req1 grant"); end
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    tests++; if (owner !== 2'b10 || blk !== 8'hB0) begin fails++; $display("FAIL contend_owner1: got %b/%h want 10/b0", owner, blk); end
    issue(1, 2'b11, 8'hB1, 8'd5, ok);
    wait_done(1, ok);
    tests++;
    if (evq.size() !== 4 || evq[0].own !== 2'b01 || evq[1].own !== 2'b01 || evq[2].own !== 2'b10 || evq[3].own !== 2'b10) begin
      fails++; $display("FAIL contend_order: got %0d pulses want 4 owned 01,01,10,10", evq.size());
    end
  endtask

  task automatic test_fairness();
    bit ok0, ok1;
    logic [1:0] order [$];
    logic [1:0] exp_o [4];
    exp_o = '{2'b01, 2'b10, 2'b01, 2'b10};
    evq.delete(); ok0 = 1'b1; ok1 = 1'b1;
    fork
      begin
        bit t;
        for (int k = 0; k < 2; k++) begin
          issue(0, 2'b01, 8'h10 + 8'(k), 8'd1, t); ok0 &= t;
          issue(0, 2'b11, 8'h20 + 8'(k), 8'd2, t); ok0 &= t;
          wait_done(0, t); ok0 &= t;
        end
      end
      begin
        bit t;
        for (int k = 0; k < 2; k++) begin
          issue(1, 2'b01, 8'h30 + 8'(k), 8'd3, t); ok1 &= t;
          issue(1, 2'b11, 8'h40 + 8'(k), 8'd4, t); ok1 &= t;
          wait_done(1, t); ok1 &= t;
        end
      end
    join
    tests++; if (!(ok0 && ok1)) begin fails++; $display("FAIL fair_complete: got %b%b want 11", ok0, ok1); end
    foreach (evq[i]) if (evq[i].op == 2'd1) order.push_back(evq[i].own);
    tests++; if (order.size() !== 4) begin fails++; $display("FAIL fair_grants: got %0d want 4", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      tests++; if (order[i] !== exp_o[i]) begin fails++; $display("FAIL fair_grant%0d: got %b want %b", i, order[i], exp_o[i]); end
    end
  endtask

  task automatic test_lock_isolation();
    bit ok;
    evq.delete();
    issue(0, 2'b01, 8'h44, 8'd8, ok);
    n_rdy1 = 0;
    cmd_valid[1] = 1'b1; cmd_op[3:2] = 2'b10; cmd_block[15:8] = 8'h99;
    issue(0, 2'b10, 8'h55, 8'd8, ok);
    issue(0, 2'b11, 8'h66, 8'd2, ok);
    wait_done(0, ok);
    repeat (3) @(negedge clk);
    cmd_valid[1] = 1'b0;
    tests++; if (n_rdy1 !== 0) begin fails++; $display("FAIL iso_ready1: got %0d cycles want 0", n_rdy1); end
    tests++;
    if (evq.size() !== 3 || evq[0].blk !== 8'h44 || evq[1].blk !== 8'h55 || evq[2].blk !== 8'h66) begin
      fails++; $display("FAIL iso_blocks: got %0d pulses want 44,55,66", evq.size());
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int err0;
    evq.delete(); err0 = n_err;
    issue(0, 2'b01, 8'h77, 8'd8, ok);
    issue(0, 2'b00, 8'hEE, 8'd1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ill_ready: got no accept want accept"); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err: got %b want 1", err); end
    tests++; if ({c_init, c_next, c_final} !== 3'b000) begin fails++; $display("FAIL ill_nopulse: got %b want 000", {c_init, c_next, c_final}); end
    tests++; if (owner !== 2'b01) begin fails++; $display("FAIL ill_owner: got %b want 01", owner); end
    @(posedge clk); #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_err_pulse: got %b want 0", err); end
    issue(0, 2'b11, 8'h78, 8'd1, ok);
    tests++; if (!ok || c_final !== 1'b1) begin fails++; $display("FAIL ill_still_locked: got ok=%b final=%b want 1/1", ok, c_final); end
    wait_done(0, ok);
    tests++; if (evq.size() !== 2 || n_err - err0 !== 1) begin fails++; $display("FAIL ill_counts: got %0d pulses %0d errs want 2/1", evq.size(), n_err - err0); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    issue(0, 2'b01, 8'h5A, 8'd8, ok);
    issue(0, 2'b10, 8'h5B, 8'd8, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (owner !== 2'b00 || done !== 2'b00 || err !== 1'b0) begin fails++; $display("FAIL rst_busy_state: got owner=%b done=%b err=%b want 00/00/0", owner, done, err); end
    tests++; if ({c_init, c_next, c_final} !== 3'b000 || blk !== 8'h00 || dlen !== 8'h00) begin fails++; $display("FAIL rst_busy_data: got %b %h %h want 000 00 00", {c_init, c_next, c_final}, blk, dlen); end
    reset = 1'b0;
    issue(1, 2'b01, 8'hC3, 8'd9, ok);
    tests++; if (!ok || owner !== 2'b10 || blk !== 8'hC3 || c_init !== 1'b1) begin fails++; $display("FAIL rst_busy_reinit: got ok=%b owner=%b blk=%h init=%b want 1/10/c3/1", ok, owner, blk, c_init); end
    issue(1, 2'b11, 8'hC4, 8'd1, ok);
    wait_done(1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_busy_done: got timeout want done"); end
  endtask

  initial begin
    test_reset();
    test_single_hash();
    test_contention();
    test_fairness();
    test_lock_isolation();
    test_illegal();
    test_reset_mid_busy();
    tests++; if (n_multi !== 0) begin fails++; $display("FAIL onehot: got %0d violating cycles want 0", n_multi); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
